// File: rtl/hex_scan_display.sv
// Multiplexed hex display driver: shadow-captured value, digit scan with
// leading-zero blanking and per-digit blinking, plus static per-digit segments.
module hex_scan_display #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [7*DIGITS-1:0]   seg_all,
  output logic                  frame
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] BLANK = 7'h7F;

  logic [4*DIGITS-1:0]     shadow_q, shadow_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic                    phase_q, phase_d;
  logic [6:0]              seg_q, seg_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [7*DIGITS-1:0]     segAll_q, segAll_d;
  logic                    frame_q, frame_d;

  logic                    tick, lastDigit, wrap, upperZero;
  logic [DIGITS-1:0][6:0]  digPat;

  function automatic logic [6:0] encodeNibble(input logic [3:0] n);
    case (n)
      4'h0: encodeNibble = 7'h40;
      4'h1: encodeNibble = 7'h79;
      4'h2: encodeNibble = 7'h24;
      4'h3: encodeNibble = 7'h30;
      4'h4: encodeNibble = 7'h19;
      4'h5: encodeNibble = 7'h12;
      4'h6: encodeNibble = 7'h02;
      4'h7: encodeNibble = 7'h78;
      4'h8: encodeNibble = 7'h00;
      4'h9: encodeNibble = 7'h10;
      4'hA: encodeNibble = 7'h08;
      4'hB: encodeNibble = 7'h03;
      4'hC: encodeNibble = 7'h46;
      4'hD: encodeNibble = 7'h21;
      4'hE: encodeNibble = 7'h06;
      default: encodeNibble = 7'h0E;
    endcase
  endfunction

  always_comb begin
    tick      = (presc_q == PW'(REFRESH_DIV - 1));
    lastDigit = (idx_q == IW'(DIGITS - 1));
    wrap      = tick && lastDigit;

    shadow_d = load ? value : shadow_q;
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (tick) idx_d = lastDigit ? '0 : idx_q + 1'b1;

    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (wrap) begin
      if (fcnt_q == FW'(BLINK_DIV - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    frame_d = wrap;

    // Walk from the top digit down so upperZero covers nibbles DIGITS-1..i.
    upperZero = 1'b1;
    digPat    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upperZero = upperZero && (shadow_q[4*i +: 4] == 4'h0);
      if (blink_en && phase_q && blink_mask[i])
        digPat[i] = BLANK;
      else if (blank_lz && (i > 0) && upperZero)
        digPat[i] = BLANK;
      else
        digPat[i] = encodeNibble(shadow_q[4*i +: 4]);
    end

    segAll_d = digPat;
    seg_d    = digPat[idx_q];
    an_d     = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      fcnt_q   <= '0;
      phase_q  <= 1'b0;
      seg_q    <= BLANK;
      an_q     <= '1;
      segAll_q <= '1;
      frame_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      fcnt_q   <= fcnt_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      segAll_q <= segAll_d;
      frame_q  <= frame_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign seg_all = segAll_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display: a time-based reference model predicts
// every post-edge output, and a monitor compares against the queued predictions.
module tb_hex_scan_display;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 2;
  localparam int FRAME_LEN   = REFRESH_DIV * DIGITS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [27:0] seg_all;
  logic        frame;

  hex_scan_display #(
    .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
    .seg(seg), .an(an), .seg_all(seg_all), .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [27:0] segAll;
    logic        frame;
  } exp_t;

  exp_t        expQ[$];
  int          checkCnt = 0;
  int          failCnt = 0;
  int          edgeNum = 0;
  logic [3:0]  modelNib [DIGITS];
  logic [6:0]  encTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] curV = '0;
  logic        curBlz = 1'b0, curBen = 1'b0;
  logic [3:0]  curMask = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checkCnt++;
    if (act !== req) begin
      failCnt++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] refDigit(int i, logic blz, logic ben, logic [3:0] mask, int phase);
    bit allZero;
    if (ben && phase == 1 && mask[i]) return 7'h7F;
    if (blz && i > 0) begin
      allZero = 1'b1;
      for (int j = i; j < DIGITS; j++) if (modelNib[j] != 4'h0) allZero = 1'b0;
      if (allZero) return 7'h7F;
    end
    return encTable[modelNib[i]];
  endfunction

  // Called at a negedge: drives inputs, predicts the next edge, waits for the next negedge.
  task automatic applyStimulus(input logic [15:0] v, input logic ld, input logic blz,
                               input logic ben, input logic [3:0] mask);
    exp_t e;
    int   idx, phase;
    value = v; load = ld; blank_lz = blz; blink_en = ben; blink_mask = mask;
    curV = v; curBlz = blz; curBen = ben; curMask = mask;
    edgeNum++;
    idx   = ((edgeNum - 1) / REFRESH_DIV) % DIGITS;
    phase = ((edgeNum - 1) / (FRAME_LEN * BLINK_DIV)) % 2;
    for (int i = 0; i < DIGITS; i++) e.segAll[7*i +: 7] = refDigit(i, blz, ben, mask, phase);
    e.seg   = e.segAll[7*idx +: 7];
    e.an    = 4'(~(1 << idx));
    e.frame = (edgeNum % FRAME_LEN == 0);
    expQ.push_back(e);
    if (ld) for (int i = 0; i < DIGITS; i++) modelNib[i] = v[4*i +: 4];
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) applyStimulus(curV, 1'b0, curBlz, curBen, curMask);
  endtask

  task automatic releaseReset();
    rst_n = 1'b1;
    edgeNum = 0;
    for (int i = 0; i < DIGITS; i++) modelNib[i] = 4'h0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("seg", 32'(seg), 32'(e.seg));
        checkOutput("an", 32'(an), 32'(e.an));
        checkOutput("seg_all", 32'(seg_all), 32'(e.segAll));
        checkOutput("frame", 32'(frame), 32'(e.frame));
      end
    end
  end

  initial begin : stimulus
    logic [15:0] rv;
    repeat (2) @(negedge clk);
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_seg_all", 32'(seg_all), 32'h0FFF_FFFF);
    checkOutput("rst_frame", 32'(frame), 32'h0);
    releaseReset();

    applyStimulus(16'h1A3F, 1'b1, 1'b0, 1'b0, 4'b0000);
    checkOutput("first_edge_seg", 32'(seg), 32'h40);
    checkOutput("first_edge_an", 32'(an), 32'hE);
    hold(40);
    checkOutput("scan_seg_all", 32'(seg_all), 32'({7'h79, 7'h08, 7'h30, 7'h0E}));

    applyStimulus(16'h0005, 1'b1, 1'b1, 1'b0, 4'b0000);
    hold(2);
    checkOutput("lz_0005", 32'(seg_all), 32'({7'h7F, 7'h7F, 7'h7F, 7'h12}));
    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0, 4'b0000);
    hold(2);
    checkOutput("lz_0000", 32'(seg_all), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
    applyStimulus(16'h0105, 1'b1, 1'b1, 1'b0, 4'b0000);
    hold(2);
    checkOutput("lz_0105", 32'(seg_all), 32'({7'h7F, 7'h79, 7'h40, 7'h12}));
    hold(20);

    applyStimulus(16'h4321, 1'b1, 1'b0, 1'b1, 4'b0010);
    hold(80);

    // Next edge lands on the prescaler terminal count.
    while (edgeNum % REFRESH_DIV != REFRESH_DIV - 1) hold(1);
    applyStimulus(16'hBEEF, 1'b1, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 12; i++) applyStimulus(16'($urandom), 1'b0, 1'b0, 1'b0, 4'b0000);

    for (int i = 0; i < 400; i++) begin
      rv = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rv[15:8] = 8'h00;
      applyStimulus(rv, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 4'($urandom));
    end

    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_seg", 32'(seg), 32'h7F);
    checkOutput("mid_rst_an", 32'(an), 32'hF);
    checkOutput("mid_rst_seg_all", 32'(seg_all), 32'h0FFF_FFFF);
    checkOutput("mid_rst_frame", 32'(frame), 32'h0);
    repeat (2) @(negedge clk);
    releaseReset();
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0, 4'b0000);
    checkOutput("post_rst_seg", 32'(seg), 32'h40);
    checkOutput("post_rst_an", 32'(an), 32'hE);
    hold(20);

    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/hex_scan_display.md
HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 Parameter DIGITS, default 4, sets the number of hex digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000, sets clk cycles per digit slot; legal range >= 2.
REQ-003 Parameter BLINK_DIV, default 256, sets full scan frames per blink-phase toggle; legal range >= 1.
REQ-004 Port clk  in  1  is the single clock; all state changes on its rising edge.
REQ-005 Port rst_n  in  1  is the reset, asynchronous and active-low.
REQ-006 Port value  in  4*DIGITS  is the hex value; nibble i drives digit i, and digit 0 is the least significant.
REQ-007 Port load  in  1  is the capture strobe for value.
REQ-008 Port blank_lz  in  1  enables leading-zero blanking.
REQ-009 Port blink_en  in  1  enables blinking globally.
REQ-010 Port blink_mask  in  DIGITS  selects which digits blink; bit i controls digit i.
REQ-011 Port seg  out  7  is the multiplexed segment bus; it is active-low, bit0=a through bit6=g.
REQ-012 Port an  out  DIGITS  is the digit enable; it is active-low and one-hot-low.
REQ-013 Port seg_all  out  7*DIGITS  is the static per-digit segments; bits [7i+6:7i] belong to digit i.
REQ-014 Port frame  out  1  is a one-cycle pulse asserted when the scan wraps from digit DIGITS-1 to digit 0.

Function
REQ-015 The encoder SHALL map nibbles to 7-bit patterns (hex) as follows: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E; the blank pattern is 7F.
REQ-016 A shadow register SHALL capture value on each clk edge where load=1 and hold otherwise; the display SHALL use only the shadow register.
REQ-017 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; the cycle at terminal count is the slot tick.
REQ-018 On each slot tick, the digit index SHALL increment, wrapping from DIGITS-1 to 0; frame SHALL assert on the cycle the wrap occurs.
REQ-019 seg and an SHALL be registered, reflecting the current index and shadow with exactly one clk of latency.
REQ-020 an SHALL have exactly one bit low (bit index), and all other bits SHALL be high.
REQ-021 For leading-zero blanking, with blank_lz=1, digit i>0 SHALL show blank when shadow nibbles DIGITS-1 down to i are all 0; digit 0 SHALL never be LZ-blanked.
REQ-022 The blink phase bit SHALL toggle after every BLINK_DIV frame pulses, using a frame counter that wraps at BLINK_DIV-1.
REQ-023 With blink_en=1, phase=1 and blink_mask[i]=1, digit i SHALL show blank; with blink_en=0, blink_mask SHALL be ignored while the phase counter keeps running.
REQ-024 Blanking priority SHALL be: blink blank, then LZ blank, then the encoded nibble.
REQ-025 seg_all SHALL be registered; each slice SHALL apply the same rules as seg for its digit, with one clk latency from the shadow register.
REQ-026 Simultaneous load and slot tick: the newly loaded nibble SHALL appear on seg one clk after the capture edge, for the new index.
REQ-027 A change on blank_lz, blink_en or blink_mask SHALL be visible on seg and seg_all one clk later; none of these inputs is captured by load.
REQ-028 When DIGITS=1, the index SHALL stay 0, an SHALL be constant 0, and frame SHALL pulse on every slot tick.

Reset
REQ-029 While rst_n=0, the shadow, prescaler, index, frame counter and phase SHALL all be 0.
REQ-030 While rst_n=0, the output reset values SHALL be: seg=7F, an all ones, seg_all all ones, frame=0.
REQ-031 Assertion of rst_n mid-scan SHALL force the reset values immediately, without waiting for clk.
REQ-032 On the first clk edge after release, seg SHALL equal 40 and an SHALL equal ~1 (digit 0 shows "0").

Verification
REQ-033 The bench SHALL cover these directed scenarios with DIGITS=4, REFRESH_DIV=4, BLINK_DIV=2, in addition to random load/blink stimulus checked against a reference model:
- Scan: load 16'h1A3F, blank_lz=0 -> an sequence 1110, 1101, 1011, 0111 with seg 0E, 30, 08, 79, each held 4 clk; frame pulses every 16 clk.
- LZ blanking: load 16'h0005, blank_lz=1 -> seg_all = {7F, 7F, 7F, 12}; load 16'h0000 -> {7F, 7F, 7F, 40}.
- Interior zero: load 16'h0105, blank_lz=1 -> seg_all = {7F, 79, 40, 12}; the zero at digit 1 is not blanked.
- Blink: blink_en=1, mask=4'b0010, value 16'h4321 -> digit 1 alternates 24/7F every 2 frames (32 clk); other digits are steady.
- Load edge: load pulse coincident with a slot tick -> the new nibble appears on seg exactly 1 clk later; with load=0, value changes have no effect.
- Reset mid-scan: drop rst_n asynchronously between edges -> seg=7F and an=1111 immediately; after release, seg=40 and an=1110 at the first edge.
